// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war scorer.
// Holds the play-state enum, default geometry and the speed-step clamp.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WON   = 2'd1,
        MATCH = 2'd2
    } play_t;

    localparam int DEF_STEPS      = 3;
    localparam int DEF_SPEED_STEP = 2;
    localparam int DEF_MATCH_LEN  = 3;

    // A fast win never moves less than one step nor jumps past the end LED.
    function automatic int clamp_speed(input int spd, input int steps);
        if (spd < 1) return 1;
        if (spd > steps) return steps;
        return spd;
    endfunction

endpackage

// File: rtl/tow_led_decode.sv
// Combinational rope display: one-hot position while playing,
// or the winner's half lit once a game is decided.
module tow_led_decode
    import tow_pkg::*;
#(
    parameter int STEPS = DEF_STEPS,
    parameter int PW    = 4
) (
    input  logic signed [PW-1:0]  pos,
    input  logic                  lwin,
    input  logic                  rwin,
    output logic [2*STEPS:0]      led
);

    for (genvar i = 0; i < 2*STEPS+1; i++) begin : g_bit
        localparam logic signed [PW-1:0] IDX = PW'(i - STEPS);
        assign led[i] = rwin ? (i > STEPS) :
                        lwin ? (i < STEPS) :
                               (pos == IDX);
    end

endmodule

// File: rtl/tow_scorer_param.sv
// Parametrised tug-of-war scorer: applies round results to a signed rope
// position, detects game wins, counts games per side and flags match end.
module tow_scorer_param
    import tow_pkg::*;
#(
    parameter int STEPS      = DEF_STEPS,
    parameter int SPEED_STEP = DEF_SPEED_STEP,
    parameter bit SNAP_BACK  = 1'b1,
    parameter int MATCH_LEN  = DEF_MATCH_LEN,
    parameter int GW         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winrnd,
    input  logic              right,
    input  logic              tie,
    input  logic              leds_on,
    input  logic              fake,
    input  logic              winspeed,
    input  logic              new_game,
    output logic [2*STEPS:0]  led,
    output logic              lwin,
    output logic              rwin,
    output logic [GW-1:0]     left_games,
    output logic [GW-1:0]     right_games,
    output logic              match_over,
    output logic              accepted,
    output logic              penalty
);

    localparam int LED_W = 2*STEPS + 1;
    localparam int SPD   = clamp_speed(SPEED_STEP, STEPS);
    // Wide enough to hold an overshoot of up to 2*STEPS either way.
    localparam int PW    = $clog2(2*STEPS + 2) + 1;
    localparam logic signed [PW-1:0] SMAX    = PW'(STEPS);
    localparam logic signed [PW-1:0] SMIN    = PW'(-STEPS);
    localparam logic [LED_W-1:0]     LED_RST = LED_W'(1) << STEPS;

    play_t                 state, state_n;
    logic signed [PW-1:0]  pos, pos_n, step, cand;
    logic                  lwin_n, rwin_n, acc_n, pen_n, toward_r;
    logic [GW-1:0]         lg_n, rg_n, lg_inc, rg_inc;
    logic [LED_W-1:0]      led_n;

    assign lg_inc = (left_games  == '1) ? left_games  : left_games  + 1'b1;
    assign rg_inc = (right_games == '1) ? right_games : right_games + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            pos         <= '0;
            led         <= LED_RST;
            lwin        <= 1'b0;
            rwin        <= 1'b0;
            left_games  <= '0;
            right_games <= '0;
            accepted    <= 1'b0;
            penalty     <= 1'b0;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            led         <= led_n;
            lwin        <= lwin_n;
            rwin        <= rwin_n;
            left_games  <= lg_n;
            right_games <= rg_n;
            accepted    <= acc_n;
            penalty     <= pen_n;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        lwin_n   = lwin;
        rwin_n   = rwin;
        lg_n     = left_games;
        rg_n     = right_games;
        acc_n    = 1'b0;
        pen_n    = 1'b0;
        toward_r = right;
        step     = PW'(1);
        cand     = pos;
        if (new_game && state != MATCH) begin
            pos_n   = '0;
            lwin_n  = 1'b0;
            rwin_n  = 1'b0;
            state_n = PLAY;
        end else if (winrnd && state == PLAY) begin
            acc_n = 1'b1;
            if (!tie) begin
                // Jump or decoy: the presser is pushed back a single step.
                if (!leds_on || fake) begin
                    toward_r = !right;
                    pen_n    = 1'b1;
                end else if (winspeed) begin
                    step = PW'(SPD);
                end
                if (SNAP_BACK && pos == SMAX && !toward_r)
                    cand = PW'(1);
                else if (SNAP_BACK && pos == SMIN && toward_r)
                    cand = PW'(-1);
                else
                    cand = toward_r ? pos + step : pos - step;

                if (cand > SMAX) begin
                    rwin_n  = 1'b1;
                    rg_n    = rg_inc;
                    state_n = (rg_inc >= GW'(MATCH_LEN)) ? MATCH : WON;
                end else if (cand < SMIN) begin
                    lwin_n  = 1'b1;
                    lg_n    = lg_inc;
                    state_n = (lg_inc >= GW'(MATCH_LEN)) ? MATCH : WON;
                end else begin
                    pos_n = cand;
                end
            end
        end
    end

    assign match_over = (state == MATCH);

    // Decode the next state so the registered display moves on the same edge.
    tow_led_decode #(.STEPS(STEPS), .PW(PW)) u_decode (
        .pos  (pos_n),
        .lwin (lwin_n),
        .rwin (rwin_n),
        .led  (led_n)
    );

endmodule

// File: tb/tb_tow_scorer_param.sv
// Bench for tow_scorer_param: two instances (snap-back on/off) checked
// every cycle against an integer model, plus pinned literal expectations.
module tb_tow_scorer_param;

    localparam int STEPS = 3;
    localparam int LED_W = 7;
    localparam int GW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, winrnd = 1'b0, right = 1'b0, tie = 1'b0;
    logic leds_on = 1'b1, fake = 1'b0, winspeed = 1'b0, new_game = 1'b0;

    logic [LED_W-1:0] led_o [2];
    logic             lwin_o [2], rwin_o [2], mo_o [2], acc_o [2], pen_o [2];
    logic [GW-1:0]    lg_o [2], rg_o [2];

    int n_chk  = 0;
    int n_pass = 0;

    int mpos [2], mlg [2], mrg [2];
    bit mlw [2], mrw [2], mmo [2], macc [2], mpen [2];
    bit snap [2] = '{1'b1, 1'b0};

    always #5 clk = ~clk;

    tow_scorer_param #(.SNAP_BACK(1'b1)) dut_snap (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie),
        .leds_on(leds_on), .fake(fake), .winspeed(winspeed), .new_game(new_game),
        .led(led_o[0]), .lwin(lwin_o[0]), .rwin(rwin_o[0]),
        .left_games(lg_o[0]), .right_games(rg_o[0]), .match_over(mo_o[0]),
        .accepted(acc_o[0]), .penalty(pen_o[0])
    );

    tow_scorer_param #(.SNAP_BACK(1'b0)) dut_nosnap (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie),
        .leds_on(leds_on), .fake(fake), .winspeed(winspeed), .new_game(new_game),
        .led(led_o[1]), .lwin(lwin_o[1]), .rwin(rwin_o[1]),
        .left_games(lg_o[1]), .right_games(rg_o[1]), .match_over(mo_o[1]),
        .accepted(acc_o[1]), .penalty(pen_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [LED_W-1:0] exp_led(input int d);
        logic [LED_W-1:0] one = LED_W'(1);
        if (mrw[d]) return 7'b1110000;
        if (mlw[d]) return 7'b0000111;
        return one << (mpos[d] + STEPS);
    endfunction

    task automatic model_step(input int d);
        int dir, mag, np;
        macc[d] = 0;
        mpen[d] = 0;
        if (rst) begin
            mpos[d] = 0; mlw[d] = 0; mrw[d] = 0; mlg[d] = 0; mrg[d] = 0; mmo[d] = 0;
        end else if (new_game) begin
            if (!mmo[d]) begin
                mpos[d] = 0; mlw[d] = 0; mrw[d] = 0;
            end
        end else if (winrnd && !mmo[d] && !mlw[d] && !mrw[d]) begin
            macc[d] = 1;
            if (!tie) begin
                dir = right ? 1 : -1;
                mag = winspeed ? 2 : 1;
                if (!leds_on || fake) begin
                    dir = -dir; mag = 1; mpen[d] = 1;
                end
                if (snap[d] && (mpos[d] == STEPS || mpos[d] == -STEPS) && dir * mpos[d] < 0)
                    np = (mpos[d] > 0) ? 1 : -1;
                else
                    np = mpos[d] + dir * mag;
                if (np > STEPS) begin
                    mrw[d] = 1;
                    if (mrg[d] < 15) mrg[d]++;
                    if (mrg[d] >= 3) mmo[d] = 1;
                end else if (np < -STEPS) begin
                    mlw[d] = 1;
                    if (mlg[d] < 15) mlg[d]++;
                    if (mlg[d] >= 3) mmo[d] = 1;
                end else begin
                    mpos[d] = np;
                end
            end
        end
    endtask

    // One clock: advance model with the inputs the DUT just sampled, then compare.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            chk($sformatf("led%0d", d),   led_o[d],  exp_led(d));
            chk($sformatf("lwin%0d", d),  lwin_o[d], mlw[d]);
            chk($sformatf("rwin%0d", d),  rwin_o[d], mrw[d]);
            chk($sformatf("lgames%0d", d), lg_o[d],  mlg[d]);
            chk($sformatf("rgames%0d", d), rg_o[d],  mrg[d]);
            chk($sformatf("match%0d", d), mo_o[d],   mmo[d]);
            chk($sformatf("acc%0d", d),   acc_o[d],  macc[d]);
            chk($sformatf("pen%0d", d),   pen_o[d],  mpen[d]);
        end
    endtask

    task automatic ev(input bit r, input bit lo, input bit f, input bit ws, input bit t);
        winrnd = 1; right = r; leds_on = lo; fake = f; winspeed = ws; tie = t;
        tick();
        winrnd = 0; tie = 0; fake = 0; winspeed = 0; leds_on = 1;
    endtask

    task automatic ng();
        new_game = 1;
        tick();
        new_game = 0;
    endtask

    initial begin
        // Reset
        rst = 1; tick(); rst = 0;
        chk("rst led", led_o[0], 7'b0001000);
        chk("rst games", rg_o[0] + lg_o[0], 0);

        // Four legal right wins
        ev(1, 1, 0, 0, 0); chk("r1 led", led_o[0], 7'b0010000); chk("r1 acc", acc_o[0], 1);
        ev(1, 1, 0, 0, 0); chk("r2 led", led_o[0], 7'b0100000);
        ev(1, 1, 0, 0, 0); chk("r3 led", led_o[0], 7'b1000000);
        ev(1, 1, 0, 0, 0); chk("r4 led", led_o[0], 7'b1110000);
        chk("r4 rwin", rwin_o[0], 1); chk("r4 games", rg_o[0], 1);
        ev(1, 1, 0, 0, 0); chk("won ignore acc", acc_o[0], 0);

        // Snap-back from +3
        ng();
        repeat (3) ev(1, 1, 0, 0, 0);
        ev(0, 1, 0, 0, 0);
        chk("snap led", led_o[0], 7'b0010000);
        chk("nosnap led", led_o[1], 7'b0100000);

        // Penalties and tie
        ng();
        ev(1, 1, 0, 0, 0); ev(1, 1, 0, 0, 0);
        ev(1, 0, 0, 0, 0);
        chk("jump led", led_o[0], 7'b0010000); chk("jump pen", pen_o[0], 1);
        ng();
        ev(0, 1, 1, 1, 0);
        chk("fake led", led_o[0], 7'b0010000); chk("fake pen", pen_o[0], 1);
        ev(1, 1, 0, 0, 1);
        chk("tie led", led_o[0], 7'b0010000); chk("tie acc", acc_o[0], 1);
        chk("tie pen", pen_o[0], 0);

        // Speed bonus
        ng(); ev(1, 1, 0, 1, 0); chk("spd0 led", led_o[0], 7'b0100000);
        ng(); ev(0, 1, 0, 0, 0); ev(1, 1, 0, 1, 0); chk("spd-1 led", led_o[0], 7'b0010000);
        ng(); ev(1, 1, 0, 1, 0); ev(1, 1, 0, 1, 0); chk("spd win", rwin_o[0], 1);

        // Match of three right games
        rst = 1; tick(); rst = 0;
        for (int g = 0; g < 3; g++) begin
            ng();
            repeat (4) ev(1, 1, 0, 0, 0);
        end
        chk("match over", mo_o[0], 1); chk("match games", rg_o[0], 3);
        ng();
        chk("match ng led", led_o[0], 7'b1110000); chk("match ng mo", mo_o[0], 1);
        ev(0, 1, 0, 0, 0); chk("match acc", acc_o[0], 0);

        // new_game beats winrnd in the same cycle
        rst = 1; tick(); rst = 0;
        ev(1, 1, 0, 0, 0);
        new_game = 1; ev(1, 1, 0, 0, 0); new_game = 0;
        chk("ng+win led", led_o[0], 7'b0001000); chk("ng+win acc", acc_o[0], 0);
        rst = 1; tick(); rst = 0;
        chk("rst2 led", led_o[0], 7'b0001000); chk("rst2 mo", mo_o[0], 0);

        // Random play
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom % 80) == 0;
            new_game = ($urandom % 10) == 0;
            winrnd   = ($urandom % 3) != 0;
            right    = 1'($urandom);
            tie      = ($urandom % 8) == 0;
            leds_on  = ($urandom % 8) != 0;
            fake     = ($urandom % 10) == 0;
            winspeed = 1'($urandom);
            tick();
        end
        rst = 0; new_game = 0; winrnd = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
